uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with input synchroniser, false-start
// rejection, optional parity, 1 or 2 stop bits, parity/framing/overrun detection
// and a valid/ready output holding register.
// Optional build macro: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID      = CW'((CLKS_PER_BIT >> 1) - 1);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          SIDX_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   sidx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bad;
  logic                   frm_bad;
  logic                   armed;
  logic                   rx_m, rx_s;
  logic                   samp;
  logic                   stop_bad;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two previous rx_s values; with the current rx_s they form the 3-sample
  // window, so the vote lands on the same cycle as a single sample would
  logic [1:0] hist;

  // Shift rx_s history for the majority vote
  always_ff @(posedge clk) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end

  assign samp = (hist[1] & hist[0]) | (rx_s & (hist[1] | hist[0]));
`else
  assign samp = rx_s;
`endif

  // A low stop sample, or one already seen in an earlier stop bit
  assign stop_bad = frm_bad | ~samp;
  assign busy     = (state != S_IDLE);

  // Receive FSM plus output holding register and handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      sidx       <= 1'b0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      frm_bad    <= 1'b0;
      armed      <= 1'b1;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          // After a framing error wait for the line to go high before
          // accepting another start, so a held break yields one word only
          if (!armed) begin
            if (rx_s) armed <= 1'b1;
          end else if (!rx_s) begin
            state <= S_START;
          end
        end

        S_START: begin
          if (cnt == MID) begin
            cnt <= '0;
            if (samp) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              idx     <= '0;
              par_bad <= 1'b0;
              frm_bad <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= samp;
            if (idx == IDX_LAST) begin
              sidx  <= 1'b0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bad <= samp ^ (^shreg) ^ PAR_ODD;
            sidx    <= 1'b0;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (sidx == SIDX_LAST) begin
              // Commit at mid-stop so a following start bit is not missed
              state <= S_IDLE;
              armed <= ~stop_bad;
              if (!valid || ready) begin
                data       <= shreg;
                parity_err <= par_bad;
                frame_err  <= stop_bad;
                valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              sidx    <= 1'b1;
              frm_bad <= stop_bad;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (16 clocks/bit, 8 data bits, even parity,
// 1 stop bit). Expected words come from a queue filled by the frame generator.
module tb_uart_rx_param;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int PAR = 2;
  localparam int SB  = 1;
  // rx fall to valid: sync + half bit + start/data/parity bits
  localparam int EXP_LAT = 2 + (CPB >> 1) + (1 + DB + ((PAR != 0) ? 1 : 0)) * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          ready = 1'b1;
  logic [DB-1:0] data;
  logic          valid, parity_err, frame_err, overrun, busy;

  typedef struct {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } word_t;

  word_t         exp_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            n_rise = 0;
  int            n_ovr = 0;
  int            cyc = 0;
  int            last_rise = 0;
  int            t_fall = 0;
  bit            rnd_ready = 1'b0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DB-1:0] prev_data = '0;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .ready(ready), .data(data),
    .valid(valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    for (int j = 0; j < CPB; j++) begin
      tick();
      rx = (glitch && j == CPB / 2) ? ~b : b;
    end
  endtask

  // One frame; the expected word is derived from what actually goes on the wire
  task automatic send(input logic [DB-1:0] d, input bit bad_par, input bit stop_low,
                      input int gbit, input bit push);
    logic  pbit;
    word_t w;
    pbit = 1'(($countones(d) % 2) ^ (PAR == 1 ? 1 : 0)) ^ bad_par;
    w.d  = d;
    w.pe = (PAR == 0) ? 1'b0 :
           (PAR == 2) ? 1'(($countones(d) + pbit) % 2 != 0)
                      : 1'(($countones(d) + pbit) % 2 == 0);
    w.fe = stop_low;
    if (push) exp_q.push_back(w);
    tick();
    rx = 1'b0;
    t_fall = cyc;
    repeat (CPB - 1) tick();
    for (int i = 0; i < DB; i++) drive_bit(d[i], i == gbit);
    if (PAR != 0) drive_bit(pbit, 1'b0);
    for (int s = 0; s < SB; s++) drive_bit(~stop_low, 1'b0);
  endtask

  // Monitor: scoreboard pops on transfer, hold-stability, event counts
  always @(negedge clk) begin
    word_t e;
    if (!reset) begin
      if (overrun) n_ovr++;
      if (valid && !prev_valid) begin
        n_rise++;
        last_rise = cyc;
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_data", 32'(data), 32'(prev_data));
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 32'(data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("data", 32'(data), 32'(e.d));
          chk("parity_err", 32'(parity_err), 32'(e.pe));
          chk("frame_err", 32'(frame_err), 32'(e.fe));
        end
      end
    end
    prev_valid = valid;
    prev_ready = ready;
    prev_data  = data;
  end

  initial begin
    int r0, o0, d;
    logic [DB-1:0] rd;
    bit bp, sl;

    // reset state
    repeat (3) tick();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_parity_err", 32'(parity_err), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    repeat (4) tick();

    // basic word and latency
    r0 = n_rise;
    send(8'hA5, 1'b0, 1'b0, -1, 1'b1);
    chk("a5_one_word", 32'(n_rise - r0), 1);
    d = last_rise - t_fall;
    chk("latency_pm1", 32'(d >= EXP_LAT - 1 && d <= EXP_LAT + 1), 1);
    tick(); rx = 1'b1;
    repeat (10) tick();

    // false start: 5 low cycles
    r0 = n_rise;
    tick(); rx = 1'b0;
    repeat (4) tick();
    chk("fs_busy_high", 32'(busy), 1);
    tick(); rx = 1'b1;
    repeat (7) tick();
    chk("fs_busy_low", 32'(busy), 0);
    chk("fs_no_word", 32'(n_rise - r0), 0);
    repeat (10) tick();

    // parity: 0x07 with wrong then right parity bit
    send(8'h07, 1'b1, 1'b0, -1, 1'b1);
    repeat (5) tick();
    send(8'h07, 1'b0, 1'b0, -1, 1'b1);
    repeat (5) tick();

    // framing error then break
    r0 = n_rise;
    send(8'h3C, 1'b0, 1'b1, -1, 1'b1);
    repeat (40) tick();
    chk("break_one_word", 32'(n_rise - r0), 1);
    chk("break_not_busy", 32'(busy), 0);
    tick(); rx = 1'b1;
    repeat (20) tick();
    send(8'h81, 1'b0, 1'b0, -1, 1'b1);
    repeat (5) tick();

    // overrun: consumer stalled, second word has nowhere to go
    tick(); ready = 1'b0;
    o0 = n_ovr;
    send(8'h11, 1'b0, 1'b0, -1, 1'b1);
    send(8'h22, 1'b0, 1'b0, -1, 1'b0);
    chk("ovr_pulses", 32'(n_ovr - o0), 1);
    chk("ovr_valid", 32'(valid), 1);
    chk("ovr_data_held", 32'(data), 32'h11);
    tick(); ready = 1'b1;
    tick();
    chk("ovr_valid_drop", 32'(valid), 0);
    repeat (10) tick();

    // reset during data bit 4
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    tick(); rx = 1'b1;
    repeat (CPB / 2 - 1) tick();
    chk("pre_rst_busy", 32'(busy), 1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    repeat (2 * CPB) tick();
    send(8'h5A, 1'b0, 1'b0, -1, 1'b1);
    repeat (5) tick();

`ifdef UART_RX_MAJORITY_EN
    // single-cycle glitch at a bit centre is outvoted
    send(8'h5A, 1'b0, 1'b0, 3, 1'b1);
    repeat (5) tick();
`endif

    // randomized frames with random consumer backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rd = DB'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 5) == 0);
      send(rd, bp, sl, -1, 1'b1);
      tick(); rx = 1'b1;
      repeat ($urandom_range(2, 20)) tick();
    end
    rnd_ready = 1'b0;
    ready = 1'b1;

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("overrun_total", 32'(n_ovr), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
